// File: rtl/fifo_rd_stream_pkg.sv
// ============================================================================
// fifo_rd_stream_pkg : default sizes, pointer-width helper, stats counter type
// Revision 1.0
// ============================================================================
`default_nettype none

package fifo_rd_stream_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BUF_DEPTH  = 3;
  localparam int DEF_PKT_LEN    = 4;

  typedef logic [15:0] stat_cnt_t;

  localparam stat_cnt_t STAT_MAX = 16'hFFFF;

  // Index width for n entries; a single-entry range still needs one bit.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_stream_buf.sv
// ============================================================================
// fifo_rd_stream_buf : circular register queue that absorbs FIFO read latency
// Revision 1.0
// ============================================================================
`default_nettype none

module fifo_rd_stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_BUF_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  logic [DATA_WIDTH-1:0]               push_data,
  input  logic                                pop,
  output logic [DATA_WIDTH-1:0]               head,
  output logic [ptr_w(DEPTH + 1)-1:0]         occ
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int OCC_W = ptr_w(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [DATA_WIDTH-1:0] buf_q [DEPTH];
  logic [DATA_WIDTH-1:0] buf_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [PTR_W-1:0]      head_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_LAST : p - 1'b1;
  endfunction

  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    if (push) begin
      buf_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // When drained, the slot behind rd_ptr still holds the last word handed out,
  // so the head keeps its value through empty gaps (all zero after reset).
  assign head_idx = (occ_q != '0) ? rd_ptr_q : ptr_dec(rd_ptr_q);
  assign head     = buf_q[head_idx];
  assign occ      = occ_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (occ_q == OCC_FULL)));

endmodule

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
// ============================================================================
// fifo_rd_stream : async_fifo read-side drain to a framed valid/ready stream
// Optional word/stall statistics ports enabled by FIFO_RD_STREAM_STATS_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
  parameter int PKT_LEN    = DEF_PKT_LEN
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
`ifdef FIFO_RD_STREAM_STATS_EN
  output stat_cnt_t             word_count,
  output stat_cnt_t             stall_count,
`endif
  output logic                  out_last
);

  localparam int OCC_W  = ptr_w(BUF_DEPTH + 1);
  localparam int BEAT_W = ptr_w(PKT_LEN);

  localparam logic [OCC_W-1:0]  OCC_MAX   = OCC_W'(BUF_DEPTH);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

  logic              inflight_q, inflight_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_sum;
  logic              pop;

  fifo_rd_stream_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head      (out_data),
    .occ       (occ)
  );

  // Credit check counts the word already in flight, so the buffer can never
  // be asked to capture while full; out_ready is deliberately not consulted.
  always_comb begin
    occ_sum    = occ + OCC_W'(inflight_q);
    fifo_rd_en = !rst && !fifo_empty && (occ_sum < OCC_MAX);
    inflight_d = fifo_rd_en;
    out_valid  = (occ != '0);
    pop        = out_valid && out_ready;
    out_last   = out_valid && (beat_cnt_q == BEAT_LAST);
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  stat_cnt_t word_count_q, word_count_d;
  stat_cnt_t stall_count_q, stall_count_d;

  // Accepted-word count wraps; stall count sticks at its maximum.
  always_comb begin
    word_count_d  = word_count_q;
    stall_count_d = stall_count_q;
    if (pop) begin
      word_count_d = word_count_q + 16'd1;
    end
    if (out_valid && !out_ready && (stall_count_q != STAT_MAX)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      word_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      word_count_q  <= word_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign word_count  = word_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
// tb_fifo_rd_stream : scoreboard bench for fifo_rd_stream with an async_fifo
// read-port model; stats checks compiled in with FIFO_RD_STREAM_STATS_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;

  localparam int DW = 8;

  logic          rd_clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0]   word_count;
  logic [15:0]   stall_count;
`endif

  logic [DW-1:0] mem [0:255];
  int            wr_idx = 0;
  int            rd_idx = 0;
  logic [DW:0]   exp_q [$];
  int            exp_beat = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            vld_cycles = 0;

  fifo_rd_stream dut (
    .rd_clk       (rd_clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
`ifdef FIFO_RD_STREAM_STATS_EN
    .word_count   (word_count),
    .stall_count  (stall_count),
`endif
    .out_last     (out_last)
  );

  always #5 rd_clk = ~rd_clk;

  // async_fifo read port: empty is combinational, data arrives one cycle after a pop
  assign fifo_empty = (wr_idx == rd_idx);

  always @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      rd_idx       <= 0;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_idx[7:0]];
      rd_idx       <= rd_idx + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Write one word into the FIFO and record the frame position it must carry.
  task automatic push_word(input logic [DW-1:0] v);
    mem[wr_idx[7:0]] = v;
    wr_idx++;
    exp_q.push_back({v, (exp_beat == 3)});
    exp_beat = (exp_beat + 1) % 4;
  endtask

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge rd_clk);
      n++;
    end
    #1;
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic start_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_beat = 0;
    wr_idx = 0;
  endtask

  // Monitor: one scoreboard comparison per accepted word
  always @(negedge rd_clk) begin
    if (rst !== 1'b1) begin
      if (out_valid) vld_cycles++;
      if (out_valid && out_ready) begin
        chk("sb_word_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          chk("sb_data_last", {23'b0, out_data, out_last}, {23'b0, e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd_vec;
    logic [15:0] vld_vec;
    int          cnt;
    int          v0;

    rd_vec    = '0;
    vld_vec   = '0;
    out_ready = 1'b0;
    start_reset();
    repeat (2) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    rst = 1'b0;

    // Basic drain
    step();
    out_ready = 1'b1;
    v0 = vld_cycles;
    for (int i = 1; i <= 4; i++) push_word(i[DW-1:0]);
    wait_drain(30);
    repeat (3) step();
    chk("basic_valid_cycles", vld_cycles - v0, 4);

    // Full throughput
    step();
    for (int i = 1; i <= 12; i++) push_word(8'h10 + i[DW-1:0]);
    for (int k = 0; k < 16; k++) begin
      @(negedge rd_clk);
      rd_vec[k]  = fifo_rd_en;
      vld_vec[k] = out_valid;
    end
    chk("thru_rd_en_pattern", rd_vec, 16'h0FFF);
    chk("thru_valid_pattern", vld_vec, 16'h3FFC);
    wait_drain(30);

    // Backpressure
    step();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(i[DW-1:0]);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge rd_clk);
      cnt += int'(fifo_rd_en);
    end
    chk("bp_pop_count", cnt, 3);
    chk("bp_out_data_held", out_data, 1);
    chk("bp_out_valid", out_valid, 1);
    step();
    out_ready = 1'b1;
    wait_drain(40);

    // Sparse source, six words so the frame is mid-packet afterwards
    step();
    v0 = vld_cycles;
    for (int i = 0; i < 6; i++) begin
      push_word(8'h30 + i[DW-1:0]);
      repeat (3) step();
    end
    wait_drain(30);
    repeat (3) step();
    chk("sparse_valid_cycles", vld_cycles - v0, 6);

    // Reset mid-stream with occ=2 and one word in flight
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'h40 + i[DW-1:0]);
    repeat (3) step();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_rd_en_saturated", fifo_rd_en, 0);
    start_reset();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_rd_en", fifo_rd_en, 0);
    chk("midrst_out_last", out_last, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'h50 + i[DW-1:0]);
    wait_drain(30);

`ifdef FIFO_RD_STREAM_STATS_EN
    step();
    start_reset();
    step();
    chk("stats_rst_words", word_count, 0);
    chk("stats_rst_stalls", stall_count, 0);
    rst = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h60 + i[DW-1:0]);
    repeat (5) step();
    out_ready = 1'b1;
    wait_drain(30);
    repeat (3) step();
    chk("stats_words", word_count, 5);
    chk("stats_stalls", stall_count, 3);
    start_reset();
    step();
    chk("stats_rst2_words", word_count, 0);
    chk("stats_rst2_stalls", stall_count, 0);
    rst = 1'b0;
    step();
`endif

    chk("sb_empty_at_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain stage that sits directly downstream of async_fifo, in the rd_clk domain.
- Pops words from the FIFO through its empty/rd_en/rd_data interface.
- Absorbs the FIFO's 1-cycle read latency in a small register buffer.
- Presents a valid/ready stream with packet framing (out_last) to the consumer.
- Sustains 1 word/cycle under no backpressure; there is no combinational path from out_ready to rd_en.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and out_data.
- BUF_DEPTH, 3, entries in the internal buffer; minimum 3 for full throughput.
- PKT_LEN, 4, words per packet; out_last marks word PKT_LEN-1 of each packet.

Ports:
- rd_clk  in  1  sole clock (FIFO read clock).
- rst  in  1  reset, asynchronous, active-high.
- fifo_empty  in  1  async_fifo empty flag.
- fifo_rd_data  in  DATA_WIDTH  async_fifo rd_data; valid the cycle after a pop.
- fifo_rd_en  out  1  pop request to async_fifo.
- out_valid  out  1  stream word available.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready at a rd_clk edge.
- out_data  out  DATA_WIDTH  stream word.
- out_last  out  1  final word of the current packet.

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately.
  - occ=0, inflight=0, wr_ptr=rd_ptr=0, beat_cnt=0.
  - out_valid=0, out_data=0, out_last=0.
  - fifo_rd_en is forced 0 while rst=1.
- Issue rule:
  - fifo_rd_en = !rst && !fifo_empty && (occ + inflight < BUF_DEPTH).
  - It is combinational from fifo_empty and registered state only.
- inflight: registered copy of fifo_rd_en, so it is 1 exactly one cycle after each pop.
- Capture: when inflight=1, fifo_rd_data is written at wr_ptr on that edge; wr_ptr advances modulo BUF_DEPTH.
- Output:
  - out_valid = (occ != 0).
  - out_data = buf[rd_ptr], registered storage with no combinational path from fifo_rd_data.
  - out_data holds its last value when out_valid=0.
- Pop: on out_valid && out_ready, rd_ptr advances modulo BUF_DEPTH.
- occ update: next occ = occ + capture - pop. Simultaneous capture and pop leaves occ unchanged.
- Latency: fifo_rd_en asserted in cycle N gives out_valid at earliest in cycle N+2. Steady-state throughput is 1 word/cycle with out_ready held high.
- Framing:
  - out_last = out_valid && (beat_cnt == PKT_LEN-1).
  - beat_cnt increments on each pop and wraps to 0 after PKT_LEN-1.
  - beat_cnt is unaffected by stalls or FIFO empty gaps.
- Backpressure:
  - With out_ready=0, occ + inflight saturates at BUF_DEPTH; no further pops are issued and no words are lost.
  - out_data and out_last stay stable while out_valid && !out_ready.
- Overflow: structurally impossible. A capture with occ==BUF_DEPTH is a design error and is flagged by an assertion.
- fifo_empty toggling: pops follow fifo_empty combinationally; gaps produce out_valid=0 bubbles and no duplicate words.
- Reset mid-operation: buffered and in-flight words are discarded and beat_cnt restarts at 0. The FIFO-side word count is the system's responsibility, since async_fifo is reset by the same rst.

Optional Feature:
- Macro: FIFO_RD_STREAM_STATS_EN.
- When defined:
  - Adds output port word_count, 16 bits: count of accepted stream words, cleared by rst, wraps at 16'hFFFF.
  - Adds output stall_count, 16 bits: cycles with out_valid && !out_ready, saturating at 16'hFFFF.
- When undefined: neither port nor its counters exists; all other behaviour is identical.

Decomposition:
- Package fifo_rd_stream_pkg contains:
  - default DATA_WIDTH/BUF_DEPTH/PKT_LEN localparams;
  - a ptr_w function, $clog2 with a minimum of 1;
  - the 16-bit stats counter type.
- One sub-module, fifo_rd_stream_buf: a circular register queue holding buf, ptrs and occ, with push/pop/head/occ ports.
- The top level holds issue logic, inflight, framing and stats.

Test Plan:
- Basic drain: write 1,2,3,4 into async_fifo, out_ready=1 → out_data 1,2,3,4 on 4 consecutive valid cycles; out_last=1 only with 4; no extra valid.
- Full throughput: 12 words preloaded, out_ready=1 → fifo_rd_en high for 12 consecutive cycles, out_valid high for 12 consecutive cycles; out_last on words 4, 8, 12.
- Backpressure: 8 words preloaded, out_ready=0 for 10 cycles → exactly 3 pops issued, out_data stays 1; release → 1..8 in order with no loss or duplication.
- Sparse source: a word written every 3rd wr_clk → out_valid pulses 1-in-3, values in order; beat_cnt framing is preserved across gaps (out_last on the 4th word).
- Reset mid-stream: assert rst with occ=2 and inflight=1 → out_valid=0, out_data=0 and fifo_rd_en=0 immediately; after release, the first accepted word has beat_cnt=0.
- Stats (FIFO_RD_STREAM_STATS_EN): 5 accepted words plus 3 stalled cycles → word_count=5, stall_count=3; both read 0 after rst.
